// File: rtl/ife_pkg.sv
// -----------------------------------------------------------------------------
// ife_pkg
// Shared types for the instruction-flow dispatcher.
//  - Default widths for the dispatcher and its interface.
//  - ife_task_t:       one queued task (start PC + instruction count).
//  - ife_disp_state_e: dispatcher FSM states.
// -----------------------------------------------------------------------------
package ife_pkg;

  localparam int IFE_NUM_CORES = 4;
  localparam int IFE_PC_W      = 32;
  localparam int IFE_LEN_W     = 8;
  localparam int IFE_STALL_W   = 16;

  typedef struct packed {
    logic [IFE_PC_W-1:0]  pc;
    logic [IFE_LEN_W-1:0] len;
  } ife_task_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2
  } ife_disp_state_e;

endpackage

// File: rtl/ife_dispatcher_if.sv
// -----------------------------------------------------------------------------
// ife_dispatcher_if
// Bundles the upstream task handshake, the core idle mask, and the per-core
// dispatch ports of ife_dispatcher.
//  - slave  modport: the dispatcher (consumes tasks, drives dispatch ports).
//  - master modport: the environment (task queue, monitor, cores).
// Optional: IFE_DISPATCH_STATS_EN adds disp_count (per-core acked dispatches).
// -----------------------------------------------------------------------------
interface ife_dispatcher_if #(
  parameter int NUM_CORES = 4,
  parameter int PC_W      = 32,
  parameter int LEN_W     = 8,
  parameter int STALL_W   = 16
);

  logic                 task_valid;
  logic                 task_ready;
  logic [PC_W-1:0]      task_pc;
  logic [LEN_W-1:0]     task_len;
  logic [NUM_CORES-1:0] core_idle_mask;
  logic [NUM_CORES-1:0] disp_valid;
  logic [PC_W-1:0]      disp_pc;
  logic [LEN_W-1:0]     disp_len;
  logic [NUM_CORES-1:0] disp_ack;
  logic [STALL_W-1:0]   stall_cnt;
`ifdef IFE_DISPATCH_STATS_EN
  logic [NUM_CORES*STALL_W-1:0] disp_count;
`endif

  modport slave (
    input  task_valid,
    input  task_pc,
    input  task_len,
    input  core_idle_mask,
    input  disp_ack,
    output task_ready,
    output disp_valid,
    output disp_pc,
    output disp_len,
    output stall_cnt
`ifdef IFE_DISPATCH_STATS_EN
    ,
    output disp_count
`endif
  );

  modport master (
    output task_valid,
    output task_pc,
    output task_len,
    output core_idle_mask,
    output disp_ack,
    input  task_ready,
    input  disp_valid,
    input  disp_pc,
    input  disp_len,
    input  stall_cnt
`ifdef IFE_DISPATCH_STATS_EN
    ,
    input  disp_count
`endif
  );

endinterface

// File: rtl/ife_dispatcher_rr_picker.sv
// -----------------------------------------------------------------------------
// ife_rr_picker
// Combinational round-robin search: finds the first set bit of req starting
// at ptr+1 and wrapping around, so the core at ptr has the lowest priority.
//  - req       in  N      candidate mask
//  - ptr       in  IDX_W  index of the last grant
//  - grant     out N      one-hot grant (zero when req is zero)
//  - grant_idx out IDX_W  index of the granted bit
//  - any       out 1      req had at least one bit set
// -----------------------------------------------------------------------------
module ife_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Walk candidates ptr+1 .. ptr+N (mod N); the first requesting one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand_s         = IDX_W'((int'(ptr) + i) % N);
      hit_s          = ~any & req[cand_s];
      grant[cand_s]  = grant[cand_s] | hit_s;
      grant_idx      = hit_s ? cand_s : grant_idx;
      any            = any | hit_s;
    end
  end

endmodule

// File: rtl/ife_dispatcher.sv
// -----------------------------------------------------------------------------
// ife_dispatcher
// Takes tasks (start PC + length) from the expander queue and hands each one
// to an idle worker core, round-robin. A core that acked a dispatch but whose
// busy flag has not yet risen is held in a local reservation so it is not
// picked twice.
//  - clk, rst                 clock, asynchronous active-high reset
//  - bus.task_valid/ready     upstream task handshake (task_pc, task_len)
//  - bus.core_idle_mask       1 = core idle, from the core monitor
//  - bus.disp_valid/ack       per-core dispatch handshake (one-hot valid)
//  - bus.disp_pc/len          dispatched task, stable while disp_valid
//  - bus.stall_cnt            saturating count of cycles with no core free
// Optional: define IFE_DISPATCH_STATS_EN to add bus.disp_count, a per-core
// saturating count of acked dispatches.
// -----------------------------------------------------------------------------
module ife_dispatcher
  import ife_pkg::*;
#(
  parameter int NUM_CORES = IFE_NUM_CORES,
  parameter int PC_W      = IFE_PC_W,
  parameter int LEN_W     = IFE_LEN_W,
  parameter int STALL_W   = IFE_STALL_W
) (
  input logic               clk,
  input logic               rst,
  ife_dispatcher_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_CORES);

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + STALL_W'(1);
  endfunction

  ife_disp_state_e      state_q, state_d;
  ife_task_t            task_q, task_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [NUM_CORES-1:0] reserved_q, reserved_d;
  logic [NUM_CORES-1:0] disp_valid_q, disp_valid_d;
  logic [PC_W-1:0]      disp_pc_q, disp_pc_d;
  logic [LEN_W-1:0]     disp_len_q, disp_len_d;
  logic                 task_ready_q, task_ready_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic [NUM_CORES-1:0] avail_s;
  logic [NUM_CORES-1:0] pick_oh_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic                 pick_any_s;
  logic                 accept_s;
  logic                 ack_hit_s;

  // Handshake qualifiers: only the granted core's ack counts.
  always_comb begin
    accept_s  = bus.task_valid & task_ready_q & (state_q == IDLE);
    ack_hit_s = (state_q == ISSUE) & bus.disp_ack[grant_idx_q];
    avail_s   = bus.core_idle_mask & ~reserved_q;
  end

  ife_rr_picker #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_picker (
    .req       (avail_s),
    .ptr       (rr_ptr_q),
    .grant     (pick_oh_s),
    .grant_idx (pick_idx_s),
    .any       (pick_any_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a zero-length task is consumed without dispatch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s && (bus.task_len != '0)) begin
          state_d = SELECT;
        end else begin
          state_d = IDLE;
        end
      end
      SELECT: begin
        if (pick_any_s) begin
          state_d = ISSUE;
        end else begin
          state_d = SELECT;
        end
      end
      ISSUE: begin
        if (ack_hit_s) begin
          state_d = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output / datapath next values.
  always_comb begin
    task_d       = task_q;
    rr_ptr_d     = rr_ptr_q;
    grant_idx_d  = grant_idx_q;
    disp_valid_d = disp_valid_q;
    disp_pc_d    = disp_pc_q;
    disp_len_d   = disp_len_q;
    stall_cnt_d  = stall_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          task_d.pc  = bus.task_pc;
          task_d.len = bus.task_len;
        end else begin
          task_d = task_q;
        end
      end
      SELECT: begin
        if (pick_any_s) begin
          rr_ptr_d     = pick_idx_s;
          grant_idx_d  = pick_idx_s;
          disp_valid_d = pick_oh_s;
          disp_pc_d    = task_q.pc;
          disp_len_d   = task_q.len;
        end else begin
          stall_cnt_d = sat_inc(stall_cnt_q);
        end
      end
      ISSUE: begin
        if (ack_hit_s) begin
          disp_valid_d = '0;
        end else begin
          disp_valid_d = disp_valid_q;
        end
      end
      default: begin
        disp_valid_d = '0;
      end
    endcase

    // Busy observation clears a reservation; a fresh ack on a still-idle core
    // sets it (the set wins because it is applied last).
    reserved_d = reserved_q & bus.core_idle_mask;
    if (ack_hit_s && bus.core_idle_mask[grant_idx_q]) begin
      reserved_d[grant_idx_q] = 1'b1;
    end else begin
      reserved_d = reserved_d;
    end

    // Registered ready keeps it low for the first cycle out of reset.
    task_ready_d = (state_d == IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      task_q       <= '0;
      rr_ptr_q     <= IDX_W'(NUM_CORES - 1);
      grant_idx_q  <= '0;
      reserved_q   <= '0;
      disp_valid_q <= '0;
      disp_pc_q    <= '0;
      disp_len_q   <= '0;
      task_ready_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      task_q       <= task_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_idx_q  <= grant_idx_d;
      reserved_q   <= reserved_d;
      disp_valid_q <= disp_valid_d;
      disp_pc_q    <= disp_pc_d;
      disp_len_q   <= disp_len_d;
      task_ready_q <= task_ready_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.task_ready = task_ready_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_pc    = disp_pc_q;
  assign bus.disp_len   = disp_len_q;
  assign bus.stall_cnt  = stall_cnt_q;

`ifdef IFE_DISPATCH_STATS_EN
  logic [NUM_CORES-1:0][STALL_W-1:0] disp_count_q, disp_count_d;

  // Per-core acked-dispatch counters.
  always_comb begin
    disp_count_d = disp_count_q;
    if (ack_hit_s) begin
      disp_count_d[grant_idx_q] = sat_inc(disp_count_q[grant_idx_q]);
    end else begin
      disp_count_d = disp_count_q;
    end
  end

  // Per-core counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_count_q <= '0;
    end else begin
      disp_count_q <= disp_count_d;
    end
  end

  assign bus.disp_count = disp_count_q;
`endif

endmodule

// File: tb/tb_ife_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_ife_dispatcher
// Directed vectors for ife_dispatcher. Each table row drives the inputs, lets
// one rising edge pass, and compares the outputs 1 time unit later. A short
// hand-written sequence covers reset asserted during an in-flight dispatch.
// -----------------------------------------------------------------------------
module tb_ife_dispatcher;

  logic clk;
  logic rst;

  ife_dispatcher_if #(
    .NUM_CORES (4),
    .PC_W      (32),
    .LEN_W     (8),
    .STALL_W   (16)
  ) bus ();

  ife_dispatcher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        tv;
    logic [31:0] pc;
    logic [7:0]  len;
    logic [3:0]  mask;
    logic [3:0]  ack;
    logic        e_ready;
    logic [3:0]  e_dv;
    logic [31:0] e_pc;
    logic [7:0]  e_len;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_err;

  task automatic add(input logic r, input logic tv, input logic [31:0] pc,
                     input logic [7:0] len, input logic [3:0] mask,
                     input logic [3:0] ack, input logic e_ready,
                     input logic [3:0] e_dv, input logic [31:0] e_pc,
                     input logic [7:0] e_len, input logic [15:0] e_stall);
    vec_t v;
    v.rst = r; v.tv = tv; v.pc = pc; v.len = len; v.mask = mask; v.ack = ack;
    v.e_ready = e_ready; v.e_dv = e_dv; v.e_pc = e_pc; v.e_len = e_len;
    v.e_stall = e_stall;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input int idx, input logic e_ready,
                               input logic [3:0] e_dv, input logic [31:0] e_pc,
                               input logic [7:0] e_len, input logic [15:0] e_stall);
    chk("task_ready", idx, 32'(bus.task_ready), 32'(e_ready));
    chk("disp_valid", idx, 32'(bus.disp_valid), 32'(e_dv));
    chk("disp_pc",    idx, bus.disp_pc,         e_pc);
    chk("disp_len",   idx, 32'(bus.disp_len),   32'(e_len));
    chk("stall_cnt",  idx, 32'(bus.stall_cnt),  32'(e_stall));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.task_valid     = 1'b0;
    bus.task_pc        = 32'h0;
    bus.task_len       = 8'h0;
    bus.core_idle_mask = 4'hF;
    bus.disp_ack       = 4'h0;

    // Single task after reset: grant core 0 two cycles after accept.
    add(1'b1, 1'b0, 32'h0,    8'd0, 4'hF, 4'h0,  1'b0, 4'h0, 32'h0,    8'd0, 16'd0);
    add(1'b0, 1'b0, 32'h0,    8'd0, 4'hF, 4'h0,  1'b1, 4'h0, 32'h0,    8'd0, 16'd0);
    add(1'b0, 1'b1, 32'h1000, 8'd4, 4'hF, 4'h0,  1'b0, 4'h0, 32'h0,    8'd0, 16'd0);
    add(1'b0, 1'b0, 32'h0,    8'd0, 4'hF, 4'h0,  1'b0, 4'h1, 32'h1000, 8'd4, 16'd0);
    add(1'b0, 1'b0, 32'h0,    8'd0, 4'hF, 4'h0,  1'b0, 4'h1, 32'h1000, 8'd4, 16'd0);
    add(1'b0, 1'b0, 32'h0,    8'd0, 4'hF, 4'h1,  1'b1, 4'h0, 32'h1000, 8'd4, 16'd0);
    add(1'b0, 1'b0, 32'h0,    8'd0, 4'hE, 4'h0,  1'b1, 4'h0, 32'h1000, 8'd4, 16'd0);

    // Back-to-back tasks, immediate ack, busy rises after ack: 0,1,2,3 then stall.
    add(1'b1, 1'b0, 32'h0,  8'd0, 4'hF, 4'h0,  1'b0, 4'h0, 32'h0,  8'd0, 16'd0);
    add(1'b0, 1'b0, 32'h0,  8'd0, 4'hF, 4'h0,  1'b1, 4'h0, 32'h0,  8'd0, 16'd0);
    add(1'b0, 1'b1, 32'hA0, 8'd1, 4'hF, 4'h0,  1'b0, 4'h0, 32'h0,  8'd0, 16'd0);
    add(1'b0, 1'b1, 32'hB0, 8'd2, 4'hF, 4'h0,  1'b0, 4'h1, 32'hA0, 8'd1, 16'd0);
    add(1'b0, 1'b1, 32'hB0, 8'd2, 4'hF, 4'h1,  1'b1, 4'h0, 32'hA0, 8'd1, 16'd0);
    add(1'b0, 1'b1, 32'hB0, 8'd2, 4'hE, 4'h0,  1'b0, 4'h0, 32'hA0, 8'd1, 16'd0);
    add(1'b0, 1'b1, 32'hC0, 8'd3, 4'hE, 4'h0,  1'b0, 4'h2, 32'hB0, 8'd2, 16'd0);
    add(1'b0, 1'b1, 32'hC0, 8'd3, 4'hE, 4'h2,  1'b1, 4'h0, 32'hB0, 8'd2, 16'd0);
    add(1'b0, 1'b1, 32'hC0, 8'd3, 4'hC, 4'h0,  1'b0, 4'h0, 32'hB0, 8'd2, 16'd0);
    add(1'b0, 1'b1, 32'hD0, 8'd4, 4'hC, 4'h0,  1'b0, 4'h4, 32'hC0, 8'd3, 16'd0);
    add(1'b0, 1'b1, 32'hD0, 8'd4, 4'hC, 4'h4,  1'b1, 4'h0, 32'hC0, 8'd3, 16'd0);
    add(1'b0, 1'b1, 32'hD0, 8'd4, 4'h8, 4'h0,  1'b0, 4'h0, 32'hC0, 8'd3, 16'd0);
    add(1'b0, 1'b1, 32'hE0, 8'd5, 4'h8, 4'h0,  1'b0, 4'h8, 32'hD0, 8'd4, 16'd0);
    add(1'b0, 1'b1, 32'hE0, 8'd5, 4'h8, 4'h8,  1'b1, 4'h0, 32'hD0, 8'd4, 16'd0);
    add(1'b0, 1'b1, 32'hE0, 8'd5, 4'h0, 4'h0,  1'b0, 4'h0, 32'hD0, 8'd4, 16'd0);
    add(1'b0, 1'b0, 32'h0,  8'd0, 4'h0, 4'h0,  1'b0, 4'h0, 32'hD0, 8'd4, 16'd1);
    add(1'b0, 1'b0, 32'h0,  8'd0, 4'h0, 4'h0,  1'b0, 4'h0, 32'hD0, 8'd4, 16'd2);

    // No core idle for 10 cycles, then only core 2 idle.
    add(1'b1, 1'b0, 32'h0,   8'd0, 4'h0, 4'h0,  1'b0, 4'h0, 32'h0, 8'd0, 16'd0);
    add(1'b0, 1'b0, 32'h0,   8'd0, 4'h0, 4'h0,  1'b1, 4'h0, 32'h0, 8'd0, 16'd0);
    add(1'b0, 1'b1, 32'hF00, 8'd7, 4'h0, 4'h0,  1'b0, 4'h0, 32'h0, 8'd0, 16'd0);
    for (int k = 1; k <= 10; k++) begin
      add(1'b0, 1'b0, 32'h0, 8'd0, 4'h0, 4'h0,  1'b0, 4'h0, 32'h0, 8'd0, 16'(k));
    end
    add(1'b0, 1'b0, 32'h0, 8'd0, 4'h4, 4'h0,  1'b0, 4'h4, 32'hF00, 8'd7, 16'd10);

    // Delayed ack with stray acks and a wandering idle mask: dispatch holds.
    add(1'b0, 1'b0, 32'h0, 8'd0, 4'h0, 4'h1,  1'b0, 4'h4, 32'hF00, 8'd7, 16'd10);
    add(1'b0, 1'b0, 32'h0, 8'd0, 4'hF, 4'h2,  1'b0, 4'h4, 32'hF00, 8'd7, 16'd10);
    add(1'b0, 1'b0, 32'h0, 8'd0, 4'h0, 4'h8,  1'b0, 4'h4, 32'hF00, 8'd7, 16'd10);
    add(1'b0, 1'b0, 32'h0, 8'd0, 4'hB, 4'hB,  1'b0, 4'h4, 32'hF00, 8'd7, 16'd10);
    add(1'b0, 1'b0, 32'h0, 8'd0, 4'h4, 4'h0,  1'b0, 4'h4, 32'hF00, 8'd7, 16'd10);
    add(1'b0, 1'b0, 32'h0, 8'd0, 4'h4, 4'h4,  1'b1, 4'h0, 32'hF00, 8'd7, 16'd10);

    // Reservation: core 1 acked while still idle is skipped until it goes busy.
    add(1'b1, 1'b0, 32'h0,   8'd0, 4'hF, 4'h0,  1'b0, 4'h0, 32'h0,   8'd0, 16'd0);
    add(1'b0, 1'b0, 32'h0,   8'd0, 4'hF, 4'h0,  1'b1, 4'h0, 32'h0,   8'd0, 16'd0);
    add(1'b0, 1'b1, 32'h100, 8'd1, 4'hF, 4'h0,  1'b0, 4'h0, 32'h0,   8'd0, 16'd0);
    add(1'b0, 1'b0, 32'h0,   8'd0, 4'hF, 4'h0,  1'b0, 4'h1, 32'h100, 8'd1, 16'd0);
    add(1'b0, 1'b0, 32'h0,   8'd0, 4'hE, 4'h1,  1'b1, 4'h0, 32'h100, 8'd1, 16'd0);
    add(1'b0, 1'b1, 32'h200, 8'd2, 4'hF, 4'h0,  1'b0, 4'h0, 32'h100, 8'd1, 16'd0);
    add(1'b0, 1'b0, 32'h0,   8'd0, 4'hF, 4'h0,  1'b0, 4'h2, 32'h200, 8'd2, 16'd0);
    add(1'b0, 1'b0, 32'h0,   8'd0, 4'hF, 4'h2,  1'b1, 4'h0, 32'h200, 8'd2, 16'd0);
    add(1'b0, 1'b1, 32'h300, 8'd3, 4'h2, 4'h0,  1'b0, 4'h0, 32'h200, 8'd2, 16'd0);
    add(1'b0, 1'b0, 32'h0,   8'd0, 4'h2, 4'h0,  1'b0, 4'h0, 32'h200, 8'd2, 16'd1);
    add(1'b0, 1'b0, 32'h0,   8'd0, 4'h0, 4'h0,  1'b0, 4'h0, 32'h200, 8'd2, 16'd2);
    add(1'b0, 1'b0, 32'h0,   8'd0, 4'h2, 4'h0,  1'b0, 4'h2, 32'h300, 8'd3, 16'd2);
    add(1'b0, 1'b0, 32'h0,   8'd0, 4'h0, 4'h2,  1'b1, 4'h0, 32'h300, 8'd3, 16'd2);
    // Zero-length task is accepted and dropped.
    add(1'b0, 1'b1, 32'h400, 8'd0, 4'hF, 4'h0,  1'b1, 4'h0, 32'h300, 8'd3, 16'd2);
    add(1'b0, 1'b0, 32'h0,   8'd0, 4'hF, 4'h0,  1'b1, 4'h0, 32'h300, 8'd3, 16'd2);
    // Task into ISSUE on core 2 (rr pointer at 1) for the reset test below.
    add(1'b0, 1'b1, 32'h500, 8'd5, 4'hF, 4'h0,  1'b0, 4'h0, 32'h300, 8'd3, 16'd2);
    add(1'b0, 1'b0, 32'h0,   8'd0, 4'hF, 4'h0,  1'b0, 4'h4, 32'h500, 8'd5, 16'd2);

    for (int i = 0; i < vecs.size(); i++) begin
      rst                = vecs[i].rst;
      bus.task_valid     = vecs[i].tv;
      bus.task_pc        = vecs[i].pc;
      bus.task_len       = vecs[i].len;
      bus.core_idle_mask = vecs[i].mask;
      bus.disp_ack       = vecs[i].ack;
      tick();
      check_outputs(i, vecs[i].e_ready, vecs[i].e_dv, vecs[i].e_pc,
                    vecs[i].e_len, vecs[i].e_stall);
    end

    // Reset during ISSUE: outputs clear without waiting for a clock edge.
    rst = 1'b1;
    #2;
    check_outputs(1000, 1'b0, 4'h0, 32'h0, 8'd0, 16'd0);
    tick();
    rst = 1'b0;
    bus.task_valid = 1'b0;
    bus.core_idle_mask = 4'hF;
    bus.disp_ack = 4'h0;
    tick();
    check_outputs(1001, 1'b1, 4'h0, 32'h0, 8'd0, 16'd0);
    bus.task_valid = 1'b1;
    bus.task_pc    = 32'h600;
    bus.task_len   = 8'd6;
    tick();
    bus.task_valid = 1'b0;
    tick();
    check_outputs(1002, 1'b0, 4'h1, 32'h600, 8'd6, 16'd0);

    // Ack and wait (bounded) for the dispatcher to come back ready.
    bus.disp_ack = 4'h1;
    begin
      int waited;
      waited = 0;
      tick();
      bus.disp_ack = 4'h0;
      while (bus.task_ready !== 1'b1 && waited < 8) begin
        tick();
        waited++;
      end
      chk("ready_after_ack", 1003, 32'(bus.task_ready), 32'd1);
      chk("ready_latency", 1003, 32'(waited), 32'd0);
      chk("dv_after_ack", 1003, 32'(bus.disp_valid), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
